// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage and the control unit that decodes opcode_id.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned PC_INC     = 4;

    // Opcode 0 decodes as no write-back and no memory access, so it doubles as the bubble.
    typedef enum logic [5:0] {
        OpNop  = 6'h00,
        OpAddi = 6'h01,
        OpLw   = 6'h02,
        OpSw   = 6'h03,
        OpBeq  = 6'h04,
        OpBne  = 6'h05,
        OpJmp  = 6'h06
    } opcode_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying PC+4, instruction and valid, with hold and bubble-flush controls.
module if_id_reg #(
    parameter int unsigned   DATA_WIDTH = 32,
    parameter logic [31:0]   NOP_INSTR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] pc_next,
    input  logic [DATA_WIDTH-1:0] instr_next,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  valid
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;

    // Hold outranks flush so a stalled stage keeps its contents even during a redirect.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (!hold) begin
            if (flush) begin
                pc_d    = '0;
                instr_d = DATA_WIDTH'(NOP_INSTR);
                valid_d = 1'b0;
            end else begin
                pc_d    = pc_next;
                instr_d = instr_next;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= DATA_WIDTH'(NOP_INSTR);
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc    = pc_q;
    assign instr = instr_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register and next-PC mux feeding the IF/ID pipeline register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  br_taken,
    input  logic [DATA_WIDTH-1:0] br_addr,
    output logic [DATA_WIDTH-1:0] inst_addr,
    input  logic [DATA_WIDTH-1:0] inst_data,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] pc_id,
    output logic [DATA_WIDTH-1:0] instr_id,
    output logic [5:0]            opcode_id,
    output logic                  valid_id
);

    localparam logic [DATA_WIDTH-1:0] WordMask = ~DATA_WIDTH'(3);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pc_plus4;

    assign pc_plus4 = pc_q + DATA_WIDTH'(PC_INC);

    always_comb begin
        pc_d = pc_q;
        if (!freeze) begin
            if (br_taken) begin
                pc_d = br_addr & WordMask;
            end else if (inst_ready) begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= DATA_WIDTH'(RESET_PC) & WordMask;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign inst_addr = pc_q & WordMask;

    // A taken branch squashes the wrong-path fetch; a memory wait inserts a bubble.
    if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .hold       (freeze),
        .flush      (br_taken | ~inst_ready),
        .pc_next    (pc_plus4),
        .instr_next (inst_data),
        .pc         (pc_id),
        .instr      (instr_id),
        .valid      (valid_id)
    );

    assign opcode_id = instr_id[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; memory word at byte address 4n is 0x04000000+n.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_addr;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic [5:0]  opcode_id;
    logic        valid_id;

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .inst_ready (inst_ready),
        .pc_id      (pc_id),
        .instr_id   (instr_id),
        .opcode_id  (opcode_id),
        .valid_id   (valid_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb inst_data = 32'h0400_0000 + {2'b00, inst_addr[31:2]};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed view: {inst_addr, pc_id, instr_id, valid_id}
    task automatic check_state(input string name, input logic [31:0] e_addr,
                               input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic e_valid);
        checks++;
        if ({inst_addr, pc_id, instr_id, valid_id} !== {e_addr, e_pc, e_instr, e_valid}) begin
            errors++;
            $display("FAIL %s: got addr=%h pc_id=%h instr=%h valid=%b want addr=%h pc_id=%h instr=%h valid=%b",
                     name, inst_addr, pc_id, instr_id, valid_id, e_addr, e_pc, e_instr, e_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_addr = '0; inst_ready = 1'b1;
        #2;
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (opcode_id !== 6'h00) begin
            errors++;
            $display("FAIL reset_opcode: got %h want 00", opcode_id);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_straight_line();
        step();
        check_state("fetch0", 32'h4, 32'h4, 32'h0400_0000, 1'b1);
        checks++;
        if (opcode_id !== 6'h01) begin
            errors++;
            $display("FAIL fetch0_opcode: got %h want 01", opcode_id);
        end
        step();
        check_state("fetch1", 32'h8, 32'h8, 32'h0400_0001, 1'b1);
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state($sformatf("freeze%0d", i), 32'h8, 32'h8, 32'h0400_0001, 1'b1);
        end
        freeze = 1'b0;
        step();
        check_state("unfreeze", 32'hC, 32'hC, 32'h0400_0002, 1'b1);
        step();
        check_state("fetch3", 32'h10, 32'h10, 32'h0400_0003, 1'b1);
    endtask

    task automatic test_branch();
        br_taken = 1'b1; br_addr = 32'h43;
        step();
        check_state("branch_flush", 32'h40, 32'h0, 32'h0, 1'b0);
        br_taken = 1'b0;
        step();
        check_state("branch_target", 32'h44, 32'h44, 32'h0400_0010, 1'b1);
    endtask

    task automatic test_freeze_branch();
        freeze = 1'b1; br_taken = 1'b1; br_addr = 32'h80;
        step();
        check_state("freeze_over_branch", 32'h44, 32'h44, 32'h0400_0010, 1'b1);
        freeze = 1'b0;
        step();
        check_state("branch_after_freeze", 32'h80, 32'h0, 32'h0, 1'b0);
        br_taken = 1'b0;
    endtask

    task automatic test_mem_wait();
        br_taken = 1'b1; br_addr = 32'h20;
        step();
        br_taken = 1'b0; inst_ready = 1'b0;
        step();
        check_state("wait0", 32'h20, 32'h0, 32'h0, 1'b0);
        step();
        check_state("wait1", 32'h20, 32'h0, 32'h0, 1'b0);
        inst_ready = 1'b1;
        step();
        check_state("wait_done", 32'h24, 32'h24, 32'h0400_0008, 1'b1);
        inst_ready = 1'b0; br_taken = 1'b1; br_addr = 32'h100;
        step();
        check_state("branch_while_wait", 32'h100, 32'h0, 32'h0, 1'b0);
        inst_ready = 1'b1; br_taken = 1'b0;
    endtask

    task automatic test_wrap_reset();
        br_taken = 1'b1; br_addr = 32'hFFFF_FFFC;
        step();
        check_state("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        br_taken = 1'b0;
        step();
        check_state("wrap", 32'h0, 32'h0, 32'h43FF_FFFF, 1'b1);
        step();
        check_state("after_wrap", 32'h4, 32'h4, 32'h0400_0000, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_state("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        #3;
        rst = 1'b0;
        step();
        check_state("post_reset_fetch", 32'h4, 32'h4, 32'h0400_0000, 1'b1);
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_freeze();
        test_branch();
        test_freeze_branch();
        test_mem_wait();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
